// File: rtl/sensor_ctrl.sv
// Sensor capture controller: fills a DEPTH-word buffer from the sensor, raises a
// level interrupt when full, and serves registered CPU reads by word index.
module sensor_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sensor_ready,
  input  logic [31:0]   sensor_out,
  output logic          sensor_en,
  input  logic          sctrl_en,
  input  logic          sctrl_clear,
  input  logic [AW-1:0] sctrl_addr,
  output logic          sctrl_interrupt,
  output logic [31:0]   sctrl_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_q;
  logic          wr_en;

  // The write is gated by sensor_ready, so an X sensor bus never reaches mem.
  assign sensor_en       = (state_q == FILL) & sctrl_en & ~sctrl_clear;
  assign wr_en           = sensor_en & sensor_ready;
  assign sctrl_interrupt = (state_q == FULL);
  assign sctrl_out       = rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sctrl_clear) begin
      cnt_d   = '0;
      state_d = sctrl_en ? FILL : IDLE;
    end else begin
      case (state_q)
        IDLE: if (sctrl_en) state_d = FILL;
        FILL: begin
          if (!sctrl_en) begin
            state_d = IDLE;
          end else if (wr_en) begin
            // cnt wraps to 0 on the write that fills the last slot.
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) state_d = FULL;
          end
        end
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[cnt_q] <= sensor_out;
    end
  end

  // Registered read; a same-cycle write to the addressed slot returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem_q[sctrl_addr];
  end

endmodule

// File: tb/tb_sensor_ctrl.sv
// Directed bench for sensor_ctrl: reset, full fill, overflow, clear, collisions, pause.
module tb_sensor_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int GAP   = 8;

  logic          clk;
  logic          rst;
  logic          sensor_ready;
  logic [31:0]   sensor_out;
  logic          sensor_en;
  logic          sctrl_en;
  logic          sctrl_clear;
  logic [AW-1:0] sctrl_addr;
  logic          sctrl_interrupt;
  logic [31:0]   sctrl_out;

  int n_tests = 0;
  int n_fail  = 0;

  sensor_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sensor_en       (sensor_en),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    sensor_ready = 1'b1;
    sensor_out   = v;
    step();
    sensor_ready = 1'b0;
    sensor_out   = 'x;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    sctrl_addr = AW'(a);
    step();
    chk(tag, sctrl_out, exp);
  endtask

  initial begin
    rst          = 1'b1;
    sensor_ready = 1'b0;
    sensor_out   = 'x;
    sctrl_en     = 1'b0;
    sctrl_clear  = 1'b0;
    sctrl_addr   = '0;
    step();
    step();
    chk("rst_sensor_en", {31'd0, sensor_en}, 32'd0);
    chk("rst_irq", {31'd0, sctrl_interrupt}, 32'd0);
    chk("rst_out", sctrl_out, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a fill with cnt=17.
    sctrl_en = 1'b1;
    step();
    chk("en_latency", {31'd0, sensor_en}, 32'd1);
    for (int i = 0; i < 17; i++) push(32'h500 + i);
    chk("pre_rst_out", sctrl_out, 32'h500);
    rst = 1'b1;
    #1;
    chk("midrst_out", sctrl_out, 32'd0);
    chk("midrst_sensor_en", {31'd0, sensor_en}, 32'd0);
    chk("midrst_irq", {31'd0, sctrl_interrupt}, 32'd0);
    step();
    sctrl_en = 1'b0;
    rst      = 1'b0;
    step();
    rd(0, 32'd0, "midrst_mem0");
    rd(16, 32'd0, "midrst_mem16");
    sctrl_en = 1'b1;
    #1;
    chk("midrst_idle", {31'd0, sensor_en}, 32'd0);

    // Full fill with idle gaps between samples.
    step();
    chk("fill_en", {31'd0, sensor_en}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      for (int g = 0; g < GAP; g++) step();
      push(32'h1000 + i);
      if (i == DEPTH - 2) chk("irq_before_last", {31'd0, sctrl_interrupt}, 32'd0);
    end
    chk("full_irq", {31'd0, sctrl_interrupt}, 32'd1);
    chk("full_sensor_en", {31'd0, sensor_en}, 32'd0);
    for (int a = 0; a < DEPTH; a++) rd(a, 32'h1000 + a, "fill_read");

    // Overflow guard.
    for (int k = 0; k < 10; k++) begin
      sensor_ready = 1'b1;
      sensor_out   = 32'hDEAD_BEEF;
      step();
    end
    sensor_ready = 1'b0;
    sensor_out   = 'x;
    chk("ovf_irq", {31'd0, sctrl_interrupt}, 32'd1);
    chk("ovf_sensor_en", {31'd0, sensor_en}, 32'd0);
    rd(0, 32'h1000, "ovf_mem0");
    rd(63, 32'h103F, "ovf_mem63");

    // Clear from FULL with enable held.
    sctrl_clear = 1'b1;
    #1;
    chk("clear_blocks_en", {31'd0, sensor_en}, 32'd0);
    step();
    sctrl_clear = 1'b0;
    #1;
    chk("clr_irq", {31'd0, sctrl_interrupt}, 32'd0);
    chk("clr_sensor_en", {31'd0, sensor_en}, 32'd1);
    sctrl_addr = '0;
    push(32'h2000);
    chk("rd_during_wr_old", sctrl_out, 32'h1000);
    step();
    chk("rd_after_wr_new", sctrl_out, 32'h2000);
    rd(1, 32'h1001, "clr_mem1_kept");

    // Clear together with sensor_ready at cnt=5.
    for (int i = 1; i < 5; i++) push(32'h2000 + i);
    sctrl_clear  = 1'b1;
    sensor_ready = 1'b1;
    sensor_out   = 32'hAAAA;
    step();
    sctrl_clear  = 1'b0;
    sensor_ready = 1'b0;
    sensor_out   = 'x;
    push(32'hBBBB);
    rd(0, 32'hBBBB, "simul_mem0");
    rd(5, 32'h1005, "simul_mem5");
    rd(4, 32'h2004, "simul_mem4");

    // Pause at cnt=30 with an X sample on the bus, then resume.
    for (int i = 1; i < 30; i++) push(32'h3000 + i);
    sctrl_en     = 1'b0;
    sensor_ready = 1'b1;
    sensor_out   = 'x;
    #1;
    chk("pause_sensor_en", {31'd0, sensor_en}, 32'd0);
    step();
    sensor_ready = 1'b0;
    rd(30, 32'h101E, "pause_mem30");
    step();
    sctrl_en = 1'b1;
    step();
    chk("resume_en", {31'd0, sensor_en}, 32'd1);
    push(32'h4444);
    rd(30, 32'h4444, "resume_mem30");
    rd(29, 32'h301D, "resume_mem29");
    rd(31, 32'h101F, "resume_mem31");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
